// File: rtl/cpu_pkg.sv
// Shared definitions for the switch-driven CPU front end: sequencer
// state encodings, ALU flag bit positions and default datapath widths.
package cpu_pkg;

    // Default widths used by the operand sequencer and its datapath.
    localparam int DW_DEF  = 16;
    localparam int OPW_DEF = 3;

    // Bit positions inside the 4-bit {Z,N,C,V} flag vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Operator entry sequence; the encoding is exported on the status LEDs,
    // so the numeric values are fixed.
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } seq_state_e;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stability-window debouncer
// and a single-cycle press pulse on each debounced rising edge.
module key_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // The window restarts whenever the input agrees with the debounced
    // level again; only an uninterrupted disagreement of DB_CYCLES flips it.
    always_comb begin
        count_d = count_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            count_d = '0;
        end else if (count_q == CW'(DB_CYCLES)) begin
            level_d = ~level_q;
            count_d = '0;
            press_d = ~level_q;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Debounce state registers; the press pulse is registered so it is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            count_q <= count_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/operand_sequencer.sv
// Operator front end for the switch-driven datapath: collects operand 1,
// operand 2 and the opcode from the switches on debounced enter presses,
// drives them to the ALU and holds the ALU result and flags for display.
module operand_sequencer
    import cpu_pkg::*;
#(
    parameter int DB_CYCLES = 250000,
    parameter int OPW       = OPW_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    sw,
    input  logic          key_enter,
    input  logic          key_clear,
    input  logic [DW-1:0] alu_out,
    input  logic [3:0]    alu_flags,
    output logic [DW-1:0] R1N,
    output logic [DW-1:0] R2N,
    output logic [7:0]    opcode,
    output logic [DW-1:0] result,
    output logic [3:0]    flags,
    output logic [2:0]    state,
    output logic          done
);

    logic enterPress;
    logic clearPress;
    logic unusedEnterLevel;
    logic unusedClearLevel;

    seq_state_e    state_q;
    seq_state_e    state_d;
    logic [DW-1:0] r1_q;
    logic [DW-1:0] r1_d;
    logic [DW-1:0] r2_q;
    logic [DW-1:0] r2_d;
    logic [7:0]    opcode_q;
    logic [7:0]    opcode_d;
    logic [DW-1:0] result_q;
    logic [DW-1:0] result_d;
    logic [3:0]    flags_q;
    logic [3:0]    flags_d;
    logic          done_q;
    logic          done_d;
    logic [DW-1:0] swOperand;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) enterDb (
        .clk   (clk),
        .rst   (rst),
        .raw   (key_enter),
        .level (unusedEnterLevel),
        .press (enterPress)
    );

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) clearDb (
        .clk   (clk),
        .rst   (rst),
        .raw   (key_clear),
        .level (unusedClearLevel),
        .press (clearPress)
    );

    // Operands are stored already sign-extended so the ALU ports come
    // straight from flops.
    assign swOperand = {{(DW-OPW){sw[OPW-1]}}, sw[OPW-1:0]};

    // Next-state and capture logic; clear outranks enter in every state,
    // and S_EXEC ignores enter entirely.
    always_comb begin
        state_d  = state_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        opcode_d = opcode_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (clearPress) begin
            state_d  = S_A;
            r1_d     = '0;
            r2_d     = '0;
            opcode_d = '0;
            result_d = '0;
            flags_d  = '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (enterPress) begin
                        r1_d    = swOperand;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (enterPress) begin
                        r2_d    = swOperand;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (enterPress) begin
                        opcode_d = sw;
                        state_d  = S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_d = alu_out;
                    flags_d  = alu_flags;
                    state_d  = S_SHOW;
                end
                S_SHOW: begin
                    if (enterPress) begin
                        state_d = S_A;
                    end
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
        done_d = (state_d == S_SHOW);
    end

    // Sequencer, operand, opcode and result holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            r1_q     <= '0;
            r2_q     <= '0;
            opcode_q <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign R1N    = r1_q;
    assign R2N    = r2_q;
    assign opcode = opcode_q;
    assign result = result_q;
    assign flags  = flags_q;
    assign state  = state_q;
    assign done   = done_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer with a short debounce window.
module tb_operand_sequencer;
    import cpu_pkg::*;

    localparam int DB   = 4;
    localparam int DW   = 16;
    localparam int OPW  = 3;
    localparam int HOLD = DB + 4;

    typedef struct packed {
        logic [15:0] r1n;
        logic [15:0] r2n;
        logic [7:0]  op;
        logic [15:0] result;
        logic [3:0]  flags;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    sw;
    logic          key_enter;
    logic          key_clear;
    logic [DW-1:0] alu_out;
    logic [3:0]    alu_flags;
    logic [DW-1:0] R1N;
    logic [DW-1:0] R2N;
    logic [7:0]    opcode;
    logic [DW-1:0] result;
    logic [3:0]    flags;
    logic [2:0]    state;
    logic          done;
    logic [15:0]   aluSum;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   popped      = 0;
    logic donePrev    = 1'b0;

    operand_sequencer #(
        .DB_CYCLES (DB),
        .OPW       (OPW),
        .DW        (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .key_enter (key_enter),
        .key_clear (key_clear),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .R1N       (R1N),
        .R2N       (R2N),
        .opcode    (opcode),
        .result    (result),
        .flags     (flags),
        .state     (state),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: adds the operands and reports zero and negative.
    assign aluSum = R1N + R2N;
    always_comb begin
        alu_out           = aluSum;
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (aluSum == 16'h0);
        alu_flags[FLAG_N] = aluSum[15];
        alu_flags[FLAG_C] = 1'b0;
        alu_flags[FLAG_V] = 1'b0;
    end

    function automatic logic [15:0] sext(input logic [2:0] v);
        return {{13{v[2]}}, v};
    endfunction

    function automatic logic [3:0] modelFlags(input logic [15:0] s);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (s == 16'h0);
        f[FLAG_N] = s[15];
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    // Hold the chosen keys long enough for a press, then release long
    // enough for the release to debounce; switches stay put throughout.
    task automatic applyStimulus(input logic enter, input logic clear, input logic [7:0] swVal);
        sw        = swVal;
        key_enter = enter;
        key_clear = clear;
        repeat (HOLD) @(negedge clk);
        key_enter = 1'b0;
        key_clear = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    function automatic exp_t makeExp(input logic [2:0] a, input logic [2:0] b, input logic [7:0] op);
        exp_t e;
        e.r1n    = sext(a);
        e.r2n    = sext(b);
        e.op     = op;
        e.result = sext(a) + sext(b);
        e.flags  = modelFlags(e.result);
        return e;
    endfunction

    // Scoreboard: each rising edge of done retires one expected transaction.
    always @(negedge clk) begin
        if (done === 1'b1 && donePrev !== 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("sbUnexpected", 32'(expQ.size()), 32'd1);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sbR1N", 32'(R1N), 32'(e.r1n));
                checkOutput("sbR2N", 32'(R2N), 32'(e.r2n));
                checkOutput("sbOpcode", 32'(opcode), 32'(e.op));
                checkOutput("sbResult", 32'(result), 32'(e.result));
                checkOutput("sbFlags", 32'(flags), 32'(e.flags));
                popped <= popped + 1;
            end
        end
        donePrev <= done;
    end

    initial begin
        int pulses;

        // Reset with both keys held high.
        rst       = 1'b1;
        key_enter = 1'b1;
        key_clear = 1'b1;
        sw        = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rstState", 32'(state), 32'(S_A));
        checkOutput("rstR1N", 32'(R1N), 32'd0);
        checkOutput("rstR2N", 32'(R2N), 32'd0);
        checkOutput("rstOpcode", 32'(opcode), 32'd0);
        checkOutput("rstResult", 32'(result), 32'd0);
        checkOutput("rstFlags", 32'(flags), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);

        rst       = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        pulses    = 0;
        repeat (HOLD + 2) begin
            @(negedge clk);
            if (dut.enterDb.press === 1'b1 || dut.clearDb.press === 1'b1) pulses++;
        end
        checkOutput("rstNoPulse", 32'(pulses), 32'd0);
        checkOutput("rstStateAfter", 32'(state), 32'(S_A));

        // Bounce: a 2-cycle high never survives a 4-cycle window.
        sw     = 8'h05;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            key_enter = (i % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                if (dut.enterDb.press === 1'b1) pulses++;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (dut.enterDb.press === 1'b1) pulses++;
        end
        checkOutput("bounceNoPulse", 32'(pulses), 32'd0);
        checkOutput("bounceState", 32'(state), 32'(S_A));

        // Clean hold: pulse after edge DB+2, capture on edge DB+3.
        key_enter = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("holdPress%0d", k), 32'(dut.enterDb.press), 32'(k == DB + 2));
            checkOutput($sformatf("holdState%0d", k), 32'(state), (k == DB + 3) ? 32'(S_B) : 32'(S_A));
        end
        key_enter = 1'b0;
        repeat (HOLD) @(negedge clk);
        checkOutput("entryR1N", 32'(R1N), 32'h0000FFFD);

        // Full entry: -3 + 2.
        applyStimulus(1'b1, 1'b0, 8'h02);
        checkOutput("entryStateOp", 32'(state), 32'(S_OP));
        checkOutput("entryR2N", 32'(R2N), 32'h00000002);
        expQ.push_back(makeExp(3'b101, 3'b010, 8'h01));
        applyStimulus(1'b1, 1'b0, 8'h01);
        checkOutput("entryStateShow", 32'(state), 32'(S_SHOW));
        checkOutput("entryDone", 32'(done), 32'd1);
        checkOutput("entryResult", 32'(result), 32'h0000FFFF);
        checkOutput("entryFlagN", 32'(flags), 32'h4);

        // Retention: leave S_SHOW, then wiggle switches without pressing.
        applyStimulus(1'b1, 1'b0, 8'hAA);
        sw = 8'h55;
        repeat (3) @(negedge clk);
        checkOutput("retState", 32'(state), 32'(S_A));
        checkOutput("retResult", 32'(result), 32'h0000FFFF);
        checkOutput("retR1N", 32'(R1N), 32'h0000FFFD);
        checkOutput("retOpcode", 32'(opcode), 32'h01);
        checkOutput("retDone", 32'(done), 32'd0);

        // Sign boundary: +3 + -4.
        applyStimulus(1'b1, 1'b0, 8'h03);
        checkOutput("signR1N", 32'(R1N), 32'h00000003);
        applyStimulus(1'b1, 1'b0, 8'h04);
        checkOutput("signR2N", 32'(R2N), 32'h0000FFFC);
        expQ.push_back(makeExp(3'b011, 3'b100, 8'h07));
        applyStimulus(1'b1, 1'b0, 8'h07);
        checkOutput("signResult", 32'(result), 32'h0000FFFF);
        checkOutput("signState", 32'(state), 32'(S_SHOW));

        // Clear during S_OP wipes everything.
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h06);
        applyStimulus(1'b1, 1'b0, 8'h01);
        checkOutput("clrPreState", 32'(state), 32'(S_OP));
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("clrState", 32'(state), 32'(S_A));
        checkOutput("clrR1N", 32'(R1N), 32'd0);
        checkOutput("clrR2N", 32'(R2N), 32'd0);
        checkOutput("clrOpcode", 32'(opcode), 32'd0);
        checkOutput("clrResult", 32'(result), 32'd0);
        checkOutput("clrFlags", 32'(flags), 32'd0);

        // Simultaneous clear and enter in S_B: clear wins, r2 untouched.
        applyStimulus(1'b1, 1'b0, 8'h02);
        checkOutput("raceR1N", 32'(R1N), 32'h00000002);
        checkOutput("racePreState", 32'(state), 32'(S_B));
        applyStimulus(1'b1, 1'b1, 8'h07);
        checkOutput("raceState", 32'(state), 32'(S_A));
        checkOutput("raceR2N", 32'(R2N), 32'd0);
        checkOutput("raceR1NCleared", 32'(R1N), 32'd0);

        checkOutput("sbDrained", 32'(expQ.size()), 32'd0);
        checkOutput("sbPopped", 32'(popped), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
